// File: rtl/el2_ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter enums for the EL2 IFU/LSU bus arbiter.
package el2_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    MST_IDLE = 2'd0,
    MST_PEND = 2'd1,
    MST_DATA = 2'd2
  } mst_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M1   = 2'b01,
    OWN_M2   = 2'b10
  } owner_e;

endpackage

// File: rtl/ahbl_req_hold.sv
// Per-master request holder: captures a losing address phase, stalls the
// master through PEND, and presents either the held or the live request.
module ahbl_req_hold
  import el2_ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic          hready,
  input  logic          fwd,
  output logic          req,
  output logic [AW-1:0] sel_addr,
  output logic [2:0]    sel_size,
  output logic          sel_write,
  output logic          hready_m,
  output mst_state_e    state
);

  mst_state_e    state_q, state_d;
  logic [AW-1:0] pend_addr_q;
  logic [2:0]    pend_size_q;
  logic          pend_write_q;
  logic          accept;
  logic          take;
  logic          unused_htrans0;

  // SEQ vs NONSEQ is irrelevant: every forwarded transfer leaves as NONSEQ.
  assign unused_htrans0 = htrans[0];

  always_comb begin
    hready_m = 1'b1;
    unique case (state_q)
      MST_PEND: hready_m = 1'b0;
      MST_DATA: hready_m = hready;
      default:  hready_m = 1'b1;
    endcase
  end

  assign accept    = htrans[1] & hready_m;
  assign take      = fwd & hready;
  assign req       = (state_q == MST_PEND) | accept;
  assign sel_addr  = (state_q == MST_PEND) ? pend_addr_q  : haddr;
  assign sel_size  = (state_q == MST_PEND) ? pend_size_q  : hsize;
  assign sel_write = (state_q == MST_PEND) ? pend_write_q : hwrite;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    if (take) begin
      state_d = MST_DATA;
    end else if (accept) begin
      state_d = MST_PEND;
    end else if ((state_q == MST_DATA) && hready) begin
      state_d = MST_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= MST_IDLE;
      pend_addr_q  <= '0;
      pend_size_q  <= '0;
      pend_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // A PEND master cannot accept, so a held entry is never overwritten.
      if (accept && !take) begin
        pend_addr_q  <= haddr;
        pend_size_q  <= hsize;
        pend_write_q <= hwrite;
      end
    end
  end

endmodule

// File: rtl/ahbl_arb_2m1s.sv
// Two-master (IFU=M1, LSU=M2) to one-slave AHB-Lite arbiter with replay.
// Define AHBL_ARB_RR_EN for round-robin; default is fixed priority M2 > M1.
module ahbl_arb_2m1s
  import el2_ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M1,
  input  logic [AW-1:0] HADDR_M2,
  input  logic [1:0]    HTRANS_M2,
  input  logic          HWRITE_M2,
  input  logic [2:0]    HSIZE_M2,
  input  logic [DW-1:0] HWDATA_M2,
  output logic          HREADY_M2,
  output logic [DW-1:0] HRDATA_M2,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  output logic [1:0]    GNT_OWNER
);

  // Handshake: a slave address phase completes on any edge where HTRANS[1]
  // and HREADY are both high; a master's phase completes when HREADY_Mx is high.
  logic          req_m1, req_m2, fwd_m1, fwd_m2;
  logic [AW-1:0] addr_m1, addr_m2;
  logic [2:0]    size_m1, size_m2;
  logic          write_m1, write_m2;
  mst_state_e    st_m1, st_m2;
  owner_e        grant, owner_q, lock_own_q;
  logic          lock_q;
`ifdef AHBL_ARB_RR_EN
  logic          last_m2_q;
`endif

  ahbl_req_hold #(.AW(AW)) u_hold_m1 (
    .HCLK(HCLK), .HRESET(HRESET), .haddr(HADDR_M1), .htrans(HTRANS_M1),
    .hwrite(HWRITE_M1), .hsize(HSIZE_M1), .hready(HREADY), .fwd(fwd_m1),
    .req(req_m1), .sel_addr(addr_m1), .sel_size(size_m1), .sel_write(write_m1),
    .hready_m(HREADY_M1), .state(st_m1)
  );

  ahbl_req_hold #(.AW(AW)) u_hold_m2 (
    .HCLK(HCLK), .HRESET(HRESET), .haddr(HADDR_M2), .htrans(HTRANS_M2),
    .hwrite(HWRITE_M2), .hsize(HSIZE_M2), .hready(HREADY), .fwd(fwd_m2),
    .req(req_m2), .sel_addr(addr_m2), .sel_size(size_m2), .sel_write(write_m2),
    .hready_m(HREADY_M2), .state(st_m2)
  );

  // A stalled address phase must stay on the bus unchanged until accepted.
  always_comb begin
    grant = OWN_NONE;
    if (lock_q) begin
      if ((lock_own_q == OWN_M1) && (st_m1 == MST_PEND)) grant = OWN_M1;
      else if ((lock_own_q == OWN_M2) && (st_m2 == MST_PEND)) grant = OWN_M2;
    end else if (req_m1 && req_m2) begin
`ifdef AHBL_ARB_RR_EN
      grant = last_m2_q ? OWN_M1 : OWN_M2;
`else
      grant = OWN_M2;
`endif
    end else if (req_m2) begin
      grant = OWN_M2;
    end else if (req_m1) begin
      grant = OWN_M1;
    end
  end

  assign fwd_m1 = (grant == OWN_M1);
  assign fwd_m2 = (grant == OWN_M2);

  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HSIZE  = '0;
    HWRITE = 1'b0;
    case (grant)
      OWN_M1: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = addr_m1;
        HSIZE  = size_m1;
        HWRITE = write_m1;
      end
      OWN_M2: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = addr_m2;
        HSIZE  = size_m2;
        HWRITE = write_m2;
      end
      default: ;
    endcase
  end

  always_comb begin
    HWDATA = '0;
    case (owner_q)
      OWN_M1:  HWDATA = HWDATA_M1;
      OWN_M2:  HWDATA = HWDATA_M2;
      default: HWDATA = '0;
    endcase
  end

  assign HRDATA_M1 = HRDATA;
  assign HRDATA_M2 = HRDATA;
  assign GNT_OWNER = owner_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_NONE;
      owner_q    <= OWN_NONE;
    end else if (HREADY) begin
      lock_q  <= 1'b0;
      owner_q <= grant;
    end else if (grant != OWN_NONE) begin
      lock_q     <= 1'b1;
      lock_own_q <= grant;
    end
  end

`ifdef AHBL_ARB_RR_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_m2_q <= 1'b0;
    end else if (HREADY && (grant != OWN_NONE)) begin
      last_m2_q <= (grant == OWN_M2);
    end
  end
`endif

endmodule

// File: tb/tb_ahbl_arb_2m1s.sv
// Directed bench for ahbl_arb_2m1s: inline checks plus a data-phase scoreboard.
module tb_ahbl_arb_2m1s;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RW = 2 + 1 + AW + DW;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [AW-1:0] HADDR_M1, HADDR_M2, HADDR;
  logic [1:0]    HTRANS_M1, HTRANS_M2, HTRANS;
  logic          HWRITE_M1, HWRITE_M2, HWRITE;
  logic [2:0]    HSIZE_M1, HSIZE_M2, HSIZE;
  logic [DW-1:0] HWDATA_M1, HWDATA_M2, HWDATA;
  logic          HREADY_M1, HREADY_M2, HREADY;
  logic [DW-1:0] HRDATA_M1, HRDATA_M2, HRDATA;
  logic [1:0]    GNT_OWNER;

  ahbl_arb_2m1s #(.AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
    .HRDATA_M1(HRDATA_M1),
    .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2),
    .HSIZE_M2(HSIZE_M2), .HWDATA_M2(HWDATA_M2), .HREADY_M2(HREADY_M2),
    .HRDATA_M2(HRDATA_M2),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .GNT_OWNER(GNT_OWNER)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [RW-1:0] exp_q[$];

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [1:0] own, input logic wr,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {own, wr, a, (wr ? d : {DW{1'b0}})};
  endfunction

  task automatic idle_m1();
    HTRANS_M1 = 2'b00; HADDR_M1 = '0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd0;
  endtask

  task automatic idle_m2();
    HTRANS_M2 = 2'b00; HADDR_M2 = '0; HWRITE_M2 = 1'b0; HSIZE_M2 = 3'd0;
  endtask

  task automatic drive_m1(input logic [1:0] tr, input logic [AW-1:0] a, input logic wr);
    HTRANS_M1 = tr; HADDR_M1 = a; HWRITE_M1 = wr; HSIZE_M1 = 3'd3;
  endtask

  task automatic drive_m2(input logic [1:0] tr, input logic [AW-1:0] a, input logic wr);
    HTRANS_M2 = tr; HADDR_M2 = a; HWRITE_M2 = wr; HSIZE_M2 = 3'd3;
  endtask

  // Both masters stream reads; each advances only when its HREADY_Mx accepts.
  task automatic run_both(input int lim1, input int lim2);
    int n1 = 0;
    int n2 = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (n1 < lim1) drive_m1(2'b10, 32'h1000 + 32'(n1 * 8), 1'b0);
      else idle_m1();
      if (n2 < lim2) drive_m2(2'b10, 32'h2000 + 32'(n2 * 8), 1'b0);
      else idle_m2();
      #1;
      if (HREADY_M1 && HTRANS_M1[1]) n1++;
      if (HREADY_M2 && HTRANS_M2[1]) n2++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic          cap_v;
    logic          cap_w;
    logic [AW-1:0] cap_a;
    logic [RW-1:0] act;
    logic [RW-1:0] e;
    cap_v = 1'b0;
    cap_w = 1'b0;
    cap_a = '0;
    forever begin
      @(negedge HCLK);
      if (mon_en) begin
        if ((GNT_OWNER != 2'b00) && HREADY) begin
          act = {GNT_OWNER, cap_w, cap_a, (cap_w ? HWDATA : {DW{1'b0}})};
          n_cmp++;
          if (!cap_v || (exp_q.size() == 0)) begin
            n_err++;
            $display("FAIL dphase_unexpected: got owner %0d addr 0x%0h, expected no data phase",
                     GNT_OWNER, cap_a);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              n_err++;
              $display("FAIL dphase: got own=%0d wr=%0b addr=0x%0h wd=0x%0h expected own=%0d wr=%0b addr=0x%0h wd=0x%0h",
                       act[RW-1 -: 2], act[AW+DW], act[AW+DW-1 -: AW], act[DW-1:0],
                       e[RW-1 -: 2], e[AW+DW], e[AW+DW-1 -: AW], e[DW-1:0]);
            end
          end
        end
        if (HREADY) begin
          cap_v = HTRANS[1];
          cap_a = HADDR;
          cap_w = HWRITE;
        end
        if (HRESET) cap_v = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    HRESET = 1'b1;
    idle_m1();
    idle_m2();
    HWDATA_M1 = 64'h1111_2222_3333_4444;
    HWDATA_M2 = 64'h0;
    HREADY = 1'b1;
    HRDATA = 64'h0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rst_hready_m1", 64'(HREADY_M1), 64'h1);
    chk("rst_hready_m2", 64'(HREADY_M2), 64'h1);
    chk("rst_htrans", 64'(HTRANS), 64'h0);
    chk("rst_haddr", 64'(HADDR), 64'h0);
    chk("rst_hwdata", HWDATA, 64'h0);
    chk("rst_owner", 64'(GNT_OWNER), 64'h0);

    // Uncontended M1 read: same-cycle forward, owner next cycle.
    tick();
    drive_m1(2'b10, 32'h0000_0100, 1'b0);
    exp_q.push_back(mk(2'b01, 1'b0, 32'h100, '0));
    #1;
    chk("t1_htrans", 64'(HTRANS), 64'h2);
    chk("t1_haddr", 64'(HADDR), 64'h100);
    chk("t1_hsize", 64'(HSIZE), 64'h3);
    tick();
    idle_m1();
    HRDATA = 64'hCAFE_F00D_1234_5678;
    #1;
    chk("t1_owner", 64'(GNT_OWNER), 64'h1);
    chk("t1_hrdata_m1", HRDATA_M1, 64'hCAFE_F00D_1234_5678);

    // Simultaneous M1 read / M2 write: M2 first, M1 replayed next cycle.
    tick();
    drive_m1(2'b10, 32'h0000_0100, 1'b0);
    drive_m2(2'b10, 32'h2000_0000, 1'b1);
    HWDATA_M2 = 64'hDEAD_BEEF_0000_0001;
    exp_q.push_back(mk(2'b10, 1'b1, 32'h2000_0000, 64'hDEAD_BEEF_0000_0001));
    exp_q.push_back(mk(2'b01, 1'b0, 32'h100, '0));
    #1;
    chk("t2_haddr_m2", 64'(HADDR), 64'h2000_0000);
    chk("t2_hwrite", 64'(HWRITE), 64'h1);
    tick();
    idle_m1();
    idle_m2();
    #1;
    chk("t2_hready_m1_pend", 64'(HREADY_M1), 64'h0);
    chk("t2_replay_haddr", 64'(HADDR), 64'h100);
    chk("t2_replay_htrans", 64'(HTRANS), 64'h2);
    chk("t2_hwdata", HWDATA, 64'hDEAD_BEEF_0000_0001);
    chk("t2_owner_m2", 64'(GNT_OWNER), 64'h2);
    tick();
    #1;
    chk("t2_hready_m1_data", 64'(HREADY_M1), 64'h1);
    chk("t2_owner_m1", 64'(GNT_OWNER), 64'h1);

    // Slave stalls 3 cycles with M2 on the bus; M1 captured meanwhile.
    tick();
    drive_m2(2'b10, 32'h2000_0004, 1'b0);
    drive_m1(2'b10, 32'h0000_0300, 1'b0);
    HREADY = 1'b0;
    exp_q.push_back(mk(2'b10, 1'b0, 32'h2000_0004, '0));
    exp_q.push_back(mk(2'b01, 1'b0, 32'h300, '0));
    #1;
    chk("t3_haddr_c0", 64'(HADDR), 64'h2000_0004);
    tick();
    idle_m1();
    idle_m2();
    #1;
    chk("t3_haddr_c1", 64'(HADDR), 64'h2000_0004);
    chk("t3_hready_m1", 64'(HREADY_M1), 64'h0);
    chk("t3_hready_m2", 64'(HREADY_M2), 64'h0);
    tick();
    #1;
    chk("t3_haddr_c2", 64'(HADDR), 64'h2000_0004);
    tick();
    HREADY = 1'b1;
    #1;
    chk("t3_haddr_release", 64'(HADDR), 64'h2000_0004);
    tick();
    HRDATA = 64'h0BAD_0000_5555_AAAA;
    #1;
    chk("t3_m1_issue", 64'(HADDR), 64'h300);
    chk("t3_owner_m2", 64'(GNT_OWNER), 64'h2);
    chk("t3_hrdata_m2", HRDATA_M2, 64'h0BAD_0000_5555_AAAA);
    tick();
    #1;
    chk("t3_owner_m1", 64'(GNT_OWNER), 64'h1);

    // Reset with M1 pending and M2 in its data phase: nothing replays.
    tick();
    drive_m2(2'b10, 32'h2000_0008, 1'b0);
    drive_m1(2'b10, 32'h0000_0108, 1'b0);
    exp_q.push_back(mk(2'b10, 1'b0, 32'h2000_0008, '0));
    tick();
    idle_m1();
    idle_m2();
    HRESET = 1'b1;
    #1;
    chk("t4_hready_m1_pend", 64'(HREADY_M1), 64'h0);
    tick();
    HRESET = 1'b0;
    #1;
    chk("t4_htrans", 64'(HTRANS), 64'h0);
    chk("t4_hready_m1", 64'(HREADY_M1), 64'h1);
    chk("t4_hready_m2", 64'(HREADY_M2), 64'h1);
    chk("t4_owner", 64'(GNT_OWNER), 64'h0);
    tick();
    #1;
    chk("t4_no_replay_a", 64'(HTRANS), 64'h0);
    tick();
    #1;
    chk("t4_no_replay_b", 64'(HTRANS), 64'h0);

    // Back-to-back M1 reads; SEQ leaves as NONSEQ with no bubble.
    tick();
    drive_m1(2'b10, 32'h0000_0100, 1'b0);
    exp_q.push_back(mk(2'b01, 1'b0, 32'h100, '0));
    exp_q.push_back(mk(2'b01, 1'b0, 32'h108, '0));
    #1;
    chk("t5_htrans_a", 64'(HTRANS), 64'h2);
    tick();
    drive_m1(2'b11, 32'h0000_0108, 1'b0);
    #1;
    chk("t5_htrans_b", 64'(HTRANS), 64'h2);
    chk("t5_haddr_b", 64'(HADDR), 64'h108);
    chk("t5_owner_a", 64'(GNT_OWNER), 64'h1);
    tick();
    idle_m1();
    #1;
    chk("t5_owner_b", 64'(GNT_OWNER), 64'h1);
    tick();
    #1;
    chk("t5_owner_idle", 64'(GNT_OWNER), 64'h0);

    // Continuous contention between both masters.
`ifdef AHBL_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(2'b10, 1'b0, 32'h2000 + 32'(k * 8), '0));
      exp_q.push_back(mk(2'b01, 1'b0, 32'h1000 + 32'(k * 8), '0));
    end
    run_both(4, 4);
`else
    exp_q.push_back(mk(2'b10, 1'b0, 32'h2000, '0));
    exp_q.push_back(mk(2'b10, 1'b0, 32'h2008, '0));
    exp_q.push_back(mk(2'b01, 1'b0, 32'h1000, '0));
    run_both(1, 2);
`endif
    idle_m1();
    idle_m2();

    for (int i = 0; (i < 50) && (exp_q.size() != 0); i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d transfers outstanding, expected 0", exp_q.size());
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
